// File: rtl/uart_regfile.sv
// uart_regfile: UART control/status registers with TX and RX byte FIFOs.
// Decodes regif_* access-phase strobes, returns combinational read data and
// streams bytes to/from the UART core.
// Optional feature macro: UART_REGIF_IRQ_EN (IER register and irq output).
module uart_regfile #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BAUD_RST   = 16'd27
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        regif_sel,
  input  logic        regif_enable,
  input  logic        regif_write,
  input  logic [7:0]  regif_addr,
  input  logic [31:0] regif_wdata,
  output logic [31:0] regif_rdata,
  output logic        uart_en,
  output logic        parity_en,
  output logic        parity_odd,
  output logic        stop2,
  output logic [15:0] baud_div,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_frame_err,
  input  logic        rx_parity_err,
  output logic        irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_BAUD   = 6'h01;
  localparam logic [5:0] A_STATUS = 6'h02;
  localparam logic [5:0] A_TXDATA = 6'h03;
  localparam logic [5:0] A_RXDATA = 6'h04;
  localparam logic [5:0] A_IER    = 6'h05;

  logic [3:0]  ctrl_q, ctrl_d;
  logic [15:0] baud_q, baud_d;
  // sticky: [0] rx_overrun, [1] frame_err, [2] parity_err, [3] tx_overflow
  logic [3:0]  sticky_q, sticky_d;

  logic [FIFO_DEPTH-1:0][7:0] tx_mem_q, tx_mem_d, rx_mem_q, rx_mem_d;
  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;

  logic [5:0] addr_w;
  logic       wr, rd;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, tx_push_ok;
  logic       rx_push, rx_pop, rx_push_ok;
  logic [3:0] sticky_set;
  logic       unused_bits;

  assign addr_w      = regif_addr[7:2];
  assign wr          = regif_sel & regif_enable & regif_write;
  assign rd          = regif_sel & regif_enable & ~regif_write;
  assign unused_bits = ^{regif_addr[1:0], regif_wdata[31:16]};

  assign tx_full  = (tx_count_q == DEPTH_C);
  assign tx_empty = (tx_count_q == '0);
  assign rx_full  = (rx_count_q == DEPTH_C);
  assign rx_empty = (rx_count_q == '0);

  assign uart_en    = ctrl_q[0];
  assign parity_en  = ctrl_q[1];
  assign parity_odd = ctrl_q[2];
  assign stop2      = ctrl_q[3];
  assign baud_div   = baud_q;
  assign tx_data    = tx_mem_q[tx_rp_q];
  assign tx_valid   = uart_en & ~tx_empty;

  // A pop on a full FIFO frees the slot the simultaneous push needs; a pop
  // on an empty FIFO cannot happen because both pop qualifiers require data.
  assign tx_push    = wr & (addr_w == A_TXDATA);
  assign tx_pop     = tx_valid & tx_ready;
  assign tx_push_ok = tx_push & (~tx_full | tx_pop);
  assign rx_push    = rx_valid & uart_en;
  assign rx_pop     = rd & (addr_w == A_RXDATA) & ~rx_empty;
  assign rx_push_ok = rx_push & (~rx_full | rx_pop);

  assign sticky_set = {tx_push & tx_full & ~tx_pop,
                       rx_valid & rx_parity_err,
                       rx_valid & rx_frame_err,
                       rx_push & rx_full & ~rx_pop};

  // Control, baud and sticky status register next-state
  always_comb begin
    ctrl_d   = ctrl_q;
    baud_d   = baud_q;
    sticky_d = sticky_q | sticky_set;
    if (wr && addr_w == A_CTRL) ctrl_d = regif_wdata[3:0];
    if (wr && addr_w == A_BAUD) baud_d = (regif_wdata[15:0] == 16'd0) ? 16'd1 : regif_wdata[15:0];
    if (wr && addr_w == A_STATUS) sticky_d = (sticky_q & ~regif_wdata[7:4]) | sticky_set;
  end

  // TX FIFO next-state: circular pointers plus occupancy count
  always_comb begin
    tx_mem_d   = tx_mem_q;
    tx_wp_d    = tx_wp_q;
    tx_rp_d    = tx_rp_q;
    tx_count_d = tx_count_q;
    if (tx_push_ok) begin
      tx_mem_d[tx_wp_q] = regif_wdata[7:0];
      tx_wp_d           = tx_wp_q + PW'(1);
    end
    if (tx_pop) tx_rp_d = tx_rp_q + PW'(1);
    case ({tx_push_ok, tx_pop})
      2'b10:   tx_count_d = tx_count_q + CW'(1);
      2'b01:   tx_count_d = tx_count_q - CW'(1);
      default: tx_count_d = tx_count_q;
    endcase
  end

  // RX FIFO next-state: circular pointers plus occupancy count
  always_comb begin
    rx_mem_d   = rx_mem_q;
    rx_wp_d    = rx_wp_q;
    rx_rp_d    = rx_rp_q;
    rx_count_d = rx_count_q;
    if (rx_push_ok) begin
      rx_mem_d[rx_wp_q] = rx_data;
      rx_wp_d           = rx_wp_q + PW'(1);
    end
    if (rx_pop) rx_rp_d = rx_rp_q + PW'(1);
    case ({rx_push_ok, rx_pop})
      2'b10:   rx_count_d = rx_count_q + CW'(1);
      2'b01:   rx_count_d = rx_count_q - CW'(1);
      default: rx_count_d = rx_count_q;
    endcase
  end

`ifdef UART_REGIF_IRQ_EN
  logic [2:0] ier_q, ier_d;
  logic       err_any;

  assign err_any = |sticky_q;
  assign irq     = |(ier_q & {err_any, tx_empty, ~rx_empty});

  // Interrupt enable register next-state
  always_comb begin
    ier_d = ier_q;
    if (wr && addr_w == A_IER) ier_d = regif_wdata[2:0];
  end

  // Interrupt enable register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) ier_q <= '0;
    else          ier_q <= ier_d;
  end
`else
  assign irq = 1'b0;
`endif

  // Combinational read mux; RXDATA shows the head during the access phase
  always_comb begin
    regif_rdata = '0;
    case (addr_w)
      A_CTRL:   regif_rdata[3:0]  = ctrl_q;
      A_BAUD:   regif_rdata[15:0] = baud_q;
      A_STATUS: regif_rdata[15:0] = {4'(rx_count_q), 4'(tx_count_q), sticky_q,
                                     rx_empty, rx_full, tx_empty, tx_full};
      A_RXDATA: regif_rdata[8:0]  = rx_empty ? 9'd0 : {1'b1, rx_mem_q[rx_rp_q]};
`ifdef UART_REGIF_IRQ_EN
      A_IER:    regif_rdata[2:0]  = ier_q;
`endif
      default:  regif_rdata = '0;
    endcase
  end

  // State registers; reset empties both FIFOs immediately
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_q     <= '0;
      baud_q     <= BAUD_RST;
      sticky_q   <= '0;
      tx_mem_q   <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_count_q <= '0;
      rx_mem_q   <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_count_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      baud_q     <= baud_d;
      sticky_q   <= sticky_d;
      tx_mem_q   <= tx_mem_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_count_q <= tx_count_d;
      rx_mem_q   <= rx_mem_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_count_q <= rx_count_d;
    end
  end

endmodule

// File: tb/tb_uart_regfile.sv
// Bench for uart_regfile: register vector table followed by FIFO, sticky,
// interrupt and reset sequences.
module tb_uart_regfile;

`ifdef UART_REGIF_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        regif_sel = 1'b0, regif_enable = 1'b0, regif_write = 1'b0;
  logic [7:0]  regif_addr = '0;
  logic [31:0] regif_wdata = '0;
  logic [31:0] regif_rdata;
  logic        uart_en, parity_en, parity_odd, stop2;
  logic [15:0] baud_div;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, rx_frame_err = 1'b0, rx_parity_err = 1'b0;
  logic        irq;

  int errors = 0;
  int checks = 0;

  uart_regfile #(.FIFO_DEPTH(4), .BAUD_RST(16'd27)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .regif_sel(regif_sel), .regif_enable(regif_enable), .regif_write(regif_write),
    .regif_addr(regif_addr), .regif_wdata(regif_wdata), .regif_rdata(regif_rdata),
    .uart_en(uart_en), .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .baud_div(baud_div), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit w, logic [7:0] a, logic [31:0] d, logic [31:0] e, string n);
    vec_t v;
    v.wr = w; v.addr = a; v.wdata = d; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One setup + one access-phase cycle; side-band strobes ride the access cycle.
  task automatic access(input bit w, input logic [7:0] a, input logic [31:0] d,
                        input bit rxv, input logic [7:0] rxd, input bit fe, input bit pe,
                        input bit txr, output logic [31:0] rdat);
    @(negedge PCLK);
    regif_sel = 1'b1; regif_enable = 1'b0; regif_write = w;
    regif_addr = a; regif_wdata = d;
    @(negedge PCLK);
    regif_enable = 1'b1;
    rx_valid = rxv; rx_data = rxd; rx_frame_err = fe; rx_parity_err = pe;
    tx_ready = txr;
    #1 rdat = regif_rdata;
    @(negedge PCLK);
    regif_sel = 1'b0; regif_enable = 1'b0; regif_write = 1'b0;
    rx_valid = 1'b0; rx_frame_err = 1'b0; rx_parity_err = 1'b0; tx_ready = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    access(1'b1, a, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] e);
    logic [31:0] r;
    access(1'b0, a, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, r);
    check(name, r, e);
  endtask

  task automatic rx_pulse(input logic [7:0] d, input bit fe, input bit pe);
    @(negedge PCLK);
    rx_valid = 1'b1; rx_data = d; rx_frame_err = fe; rx_parity_err = pe;
    @(negedge PCLK);
    rx_valid = 1'b0; rx_frame_err = 1'b0; rx_parity_err = 1'b0;
  endtask

  task automatic tx_pulse();
    @(negedge PCLK);
    tx_ready = 1'b1;
    @(negedge PCLK);
    tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  tx_exp [4];
    logic [31:0] rx_exp [4];
    logic [31:0] ier_exp;

    ier_exp = IRQ_EN ? 32'h7 : 32'h0;
    vecs.push_back(mk(0, 8'h00, 0, 32'h0,    "ctrl_rst"));
    vecs.push_back(mk(0, 8'h04, 0, 32'h1B,   "baud_rst"));
    vecs.push_back(mk(0, 8'h08, 0, 32'hA,    "status_rst"));
    vecs.push_back(mk(0, 8'h0C, 0, 32'h0,    "txdata_rd"));
    vecs.push_back(mk(0, 8'h10, 0, 32'h0,    "rxdata_empty"));
    vecs.push_back(mk(0, 8'h14, 0, 32'h0,    "ier_rst"));
    vecs.push_back(mk(0, 8'h40, 0, 32'h0,    "unmapped_rd"));
    vecs.push_back(mk(1, 8'h04, 0, 32'h0,    "baud_wr0"));
    vecs.push_back(mk(0, 8'h04, 0, 32'h1,    "baud_zero"));
    vecs.push_back(mk(1, 8'h06, 32'h1234, 0, "baud_wr"));
    vecs.push_back(mk(0, 8'h04, 0, 32'h1234, "baud_rw"));
    vecs.push_back(mk(1, 8'h40, 32'hFFFF_FFFF, 0, "unmapped_wr"));
    vecs.push_back(mk(0, 8'h40, 0, 32'h0,    "unmapped_rd2"));
    vecs.push_back(mk(0, 8'h00, 0, 32'h0,    "ctrl_no_alias"));
    vecs.push_back(mk(1, 8'h00, 32'hFFFF_FFFF, 0, "ctrl_wr"));
    vecs.push_back(mk(0, 8'h00, 0, 32'hF,    "ctrl_rw"));
    vecs.push_back(mk(1, 8'h14, 32'hFFFF_FFFF, 0, "ier_wr"));
    vecs.push_back(mk(0, 8'h14, 0, ier_exp,  "ier_rw"));
    vecs.push_back(mk(1, 8'h14, 32'h0, 0,    "ier_clr"));
    vecs.push_back(mk(1, 8'h00, 32'h1, 0,    "ctrl_wr1"));
    vecs.push_back(mk(0, 8'h00, 0, 32'h1,    "ctrl_en"));

    repeat (3) @(negedge PCLK);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_baud_pin", {16'b0, baud_div}, 32'h1B);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    PRESETn = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].wr) wr_reg(vecs[i].addr, vecs[i].wdata);
      else            rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end
    check("baud_pin", {16'b0, baud_div}, 32'h1234);
    check("ctrl_pins", {28'b0, stop2, parity_odd, parity_en, uart_en}, 32'h1);

    // TX: five writes into depth 4 with the core stalled
    for (int i = 0; i < 5; i++) wr_reg(8'h0C, 32'h11 + i);
    rd_chk("tx_full_status", 8'h08, 32'h489);
    check("tx_head", {24'b0, tx_data}, 32'h11);
    check("tx_valid_full", {31'b0, tx_valid}, 32'h1);
    wr_reg(8'h08, 32'h80);
    rd_chk("tx_ovf_w1c", 8'h08, 32'h409);
    // push and pop together on a full FIFO
    access(1'b1, 8'h0C, 32'h16, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, r);
    rd_chk("tx_full_pushpop", 8'h08, 32'h409);
    tx_exp[0] = 8'h12; tx_exp[1] = 8'h13; tx_exp[2] = 8'h14; tx_exp[3] = 8'h16;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tx_drain%0d", i), {24'b0, tx_data}, {24'b0, tx_exp[i]});
      tx_pulse();
    end
    check("tx_valid_empty", {31'b0, tx_valid}, 32'h0);
    rd_chk("tx_empty_status", 8'h08, 32'hA);

    // RX basic
    rx_pulse(8'h55, 1'b0, 1'b0);
    rx_pulse(8'hAA, 1'b0, 1'b0);
    rd_chk("rx_rd1", 8'h10, 32'h155);
    rd_chk("rx_rd2", 8'h10, 32'h1AA);
    rd_chk("rx_rd3", 8'h10, 32'h0);

    // RX full, simultaneous push+pop, overrun, errors, W1C
    for (int i = 1; i <= 4; i++) rx_pulse(8'(i), 1'b0, 1'b0);
    rd_chk("rx_full_status", 8'h08, 32'h4006);
    access(1'b0, 8'h10, 32'h0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, r);
    check("rx_full_pushpop_rd", r, 32'h101);
    rd_chk("rx_full_pushpop", 8'h08, 32'h4006);
    rx_pulse(8'h06, 1'b1, 1'b1);
    rd_chk("rx_overrun_err", 8'h08, 32'h4076);
    wr_reg(8'h08, 32'h70);
    rd_chk("rx_w1c", 8'h08, 32'h4006);
    access(1'b1, 8'h08, 32'h10, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, r);
    rd_chk("sticky_set_wins", 8'h08, 32'h4016);
    wr_reg(8'h08, 32'h10);
    rd_chk("overrun_clr", 8'h08, 32'h4006);
    rx_exp[0] = 32'h102; rx_exp[1] = 32'h103; rx_exp[2] = 32'h104; rx_exp[3] = 32'h105;
    for (int i = 0; i < 4; i++) rd_chk($sformatf("rx_drain%0d", i), 8'h10, rx_exp[i]);
    rd_chk("rx_drain_empty", 8'h10, 32'h0);

    // push and pop together on an empty RX FIFO
    access(1'b0, 8'h10, 32'h0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, r);
    check("rx_empty_pushpop_rd", r, 32'h0);
    rd_chk("rx_empty_pushpop", 8'h10, 32'h166);

    // interrupts
    wr_reg(8'h14, 32'h1);
    check("irq_rx_none", {31'b0, irq}, 32'h0);
    rx_pulse(8'h77, 1'b0, 1'b0);
    check("irq_rx_set", {31'b0, irq}, {31'b0, IRQ_EN});
    rd_chk("irq_rx_rd", 8'h10, 32'h177);
    check("irq_rx_clr", {31'b0, irq}, 32'h0);
    wr_reg(8'h14, 32'h4);
    rx_pulse(8'h78, 1'b1, 1'b0);
    check("irq_err_set", {31'b0, irq}, {31'b0, IRQ_EN});
    wr_reg(8'h08, 32'h20);
    check("irq_err_clr", {31'b0, irq}, 32'h0);
    wr_reg(8'h14, 32'h2);
    check("irq_tx_empty", {31'b0, irq}, {31'b0, IRQ_EN});
    wr_reg(8'h14, 32'h0);
    rd_chk("rx_last", 8'h10, 32'h178);

    // uart_en low blocks RX pushes
    wr_reg(8'h00, 32'h0);
    rx_pulse(8'h99, 1'b0, 1'b0);
    rd_chk("rx_disabled", 8'h08, 32'hA);
    wr_reg(8'h00, 32'h1);

    // reset with TX holding three bytes
    for (int i = 0; i < 3; i++) wr_reg(8'h0C, 32'hA0 + i);
    rd_chk("tx_three", 8'h08, 32'h308);
    check("tx_valid_three", {31'b0, tx_valid}, 32'h1);
    @(negedge PCLK);
    PRESETn = 1'b0;
    regif_addr = 8'h08;
    #1;
    check("rst_tx_valid_async", {31'b0, tx_valid}, 32'h0);
    check("rst_status_async", regif_rdata, 32'hA);
    regif_addr = 8'h00;
    #1;
    check("rst_ctrl_async", regif_rdata, 32'h0);
    check("rst_baud_async", {16'b0, baud_div}, 32'h1B);
    @(negedge PCLK);
    PRESETn = 1'b1;
    rd_chk("post_rst_status", 8'h08, 32'hA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_regfile.md
# uart_regfile

UART control/status register file with TX and RX byte FIFOs. Sits directly downstream of the APB-to-UART interface and consumes its `regif_*` strobes. Presents combinational read data back to that interface, which registers it onto PRDATA. Drives the UART transmit/receive core through a valid/ready byte stream.

## Interface
- FIFO_DEPTH, 4, entries per TX and RX FIFO; power of two, 2..8
- BAUD_RST, 16'd27, reset value of baud divisor
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous, active-low reset
- regif_sel  in  1  register-file select (APB PSEL)
- regif_enable  in  1  access phase (APB PENABLE)
- regif_write  in  1  1 = write, 0 = read
- regif_addr  in  8  byte address; bits [1:0] ignored
- regif_wdata  in  32  write data
- regif_rdata  out  32  read data, combinational from regif_addr
- uart_en, parity_en, parity_odd, stop2  out  1 each  CTRL fields
- baud_div  out  16  baud divisor
- tx_data  out  8  TX FIFO head
- tx_valid  out  1  uart_en & TX FIFO not empty
- tx_ready  in  1  core accepts tx_data; pops when tx_valid & tx_ready
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle push strobe
- rx_frame_err, rx_parity_err  in  1  error flags, qualified by rx_valid
- irq  out  1  level interrupt

## Operation
- wr = sel & enable & write; rd = sel & enable & ~write. Only one access-phase cycle acts.
- 0x00 CTRL RW: [0] uart_en, [1] parity_en, [2] parity_odd, [3] stop2. Reset 0.
- 0x04 BAUD RW: [15:0]. A write of 0 stores 1. Reset BAUD_RST.
- 0x08 STATUS: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty; [4] rx_overrun, [5] frame_err, [6] parity_err, [7] tx_overflow are sticky and W1C. [11:8] tx_count, [15:12] rx_count.
- 0x0C TXDATA WO: wr pushes wdata[7:0]. If full, the byte is dropped and tx_overflow is set. Reads return 0.
- 0x10 RXDATA RO: returns {23'b0, !rx_empty, head}. rd pops when not empty. When empty, returns 0 and does not pop.
- 0x14 IER RW: [0] rx_nonempty, [1] tx_empty, [2] any sticky error. Reset 0.
- irq = |(IER & {err_any, tx_empty, !rx_empty}).
- Unmapped addresses read 0; writes to them are ignored.
- RX push needs rx_valid & uart_en. If RX is full with no simultaneous pop, the byte is dropped and rx_overrun is set.
- frame_err and parity_err set on rx_valid regardless of whether the push succeeds.
- FIFOs use circular pointers with a count. Pointers wrap modulo FIFO_DEPTH.

## Timing
- regif_rdata is zero-latency combinational. RXDATA shows the head present during the access phase; the pop takes effect at the edge ending that phase.
- Register writes, pushes and pops take effect at the PCLK edge ending the access phase. Outputs reflect them the next cycle.
- Simultaneous push and pop on a full FIFO: both succeed, count is unchanged, no overflow or overrun.
- Simultaneous push and pop on an empty FIFO: the push succeeds and the pop is ignored.
- Sticky set and W1C clear in the same cycle: set wins.
- Reset values: all outputs and registers 0 except baud_div = BAUD_RST. FIFOs empty, tx_empty = rx_empty = 1, irq = 0.
- Reset mid-transfer discards FIFO contents immediately.

## Configuration
- UART_REGIF_IRQ_EN defined: IER implemented, irq as specified.
- UART_REGIF_IRQ_EN undefined:
  - IER reads 0 and writes are ignored.
  - irq is tied 0.
  - Sticky status bits are unchanged.

## Test plan
- Reset -> CTRL 0, BAUD 0x1B, STATUS 0x0000_000A, irq 0.
- Write BAUD 0 -> read 1. Write CTRL 0x1 and 5 bytes to TXDATA with tx_ready=0, depth 4 -> tx_count 4, STATUS[7]=1, tx_data = first byte.
- Pulse rx_valid with 0x55, then 0xAA -> two RXDATA reads return 0x155, 0x1AA; a third read returns 0.
- Fill RX, then assert rx_valid together with a RXDATA read -> no overrun, count stays 4. Assert rx_valid alone while full -> STATUS[4]=1. Write 0x10 to STATUS -> bit 4 clears.
- IER=0x1, push one RX byte -> irq=1; read RXDATA -> irq=0 the next cycle.
- Assert PRESETn low with TX holding 3 bytes -> tx_valid 0, tx_count 0, CTRL 0.
